rs_latch_sequencer: RTL
=======================

RS_LATCH_SEQUENCER -- requirements
Module: rs_latch_sequencer

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-high reset, rst; these polarities and synchronicity are fixed.
REQ-002 Parameter PULSE_W, default 2: number of cycles S or R is held high per operation, legal range 1..15.
REQ-003 Parameter GAP_W, default 1: number of cycles S and R are both low after each operation, legal range 1..15.
REQ-004 Parameter TIMEOUT, default 8: maximum number of cycles spent in CHECK, legal range 1..255.
REQ-005 Ports SHALL be, in order:
- clk, in, 1: clock.
- rst, in, 1: asynchronous active-high reset.
- req, in, 2: per-requester operation request, level, held until ack.
- op, in, 2: per-requester operation, 1 = set, 0 = reset; valid while the matching req bit is high.
- Q, in, 1: latch true output, asynchronous.
- Q_L, in, 1: latch complement output, asynchronous.
- S, out, 1: latch set drive.
- R, out, 1: latch reset drive.
- ack, out, 2: one-cycle completion pulse to the served requester.
- err, out, 1: valid with ack; 1 = latch did not confirm.
- busy, out, 1: high in any state other than IDLE.

Function
REQ-006 S, R, ack, err and busy SHALL be driven directly from flops.
REQ-007 S and R SHALL never be high in the same cycle.
REQ-008 Q and Q_L SHALL each pass through a 2-flop synchronizer before use, giving qs and qls.
REQ-009 The FSM SHALL have four states: IDLE, PULSE, CHECK and GAP.
REQ-010 IDLE SHALL behave as follows:
- If any req bit is high at a clock edge, the block grants one requester, latches its op bit into tgt, and enters PULSE.
- S = tgt or R = ~tgt is high starting the cycle after that edge.
REQ-011 Arbitration SHALL be round-robin:
- A single requester wins directly.
- When both requesters are high, the one not served last wins.
- The last-served pointer SHALL reset to requester 1, so requester 0 wins first.
REQ-012 In PULSE, the selected drive SHALL stay high for exactly PULSE_W cycles, then both drives go low and the FSM enters CHECK.
REQ-013 CHECK SHALL complete with success when qs == tgt and qls == ~tgt.
- Completion pulses ack[grant] = 1 with err = 0 for one cycle and the FSM enters GAP.
- The check is evaluated from the first CHECK cycle onward.
REQ-014 If CHECK has not succeeded after TIMEOUT cycles, the block SHALL pulse ack[grant] = 1 with err = 1 and enter GAP.
- qs == qls, the forbidden or metastable condition, SHALL never count as success.
REQ-015 GAP SHALL hold S = R = 0 for exactly GAP_W cycles and then return to IDLE.
- Requests are not sampled during PULSE, CHECK or GAP.
REQ-016 A req bit that drops before its ack SHALL NOT abort the operation; it completes and ack is still pulsed.
REQ-017 err SHALL be 0 whenever ack == 0.
REQ-018 At most one ack bit SHALL be high in any cycle.
REQ-019 Minimum turnaround per operation SHALL be 1 + PULSE_W + 1 + GAP_W cycles from the request edge to the next grant opportunity, assuming immediate confirmation.

Reset
REQ-020 While rst is high, state, outputs and pointer SHALL take these values asynchronously:
- state = IDLE; S = R = 0; ack = 0; err = 0; busy = 0.
- Counters = 0; tgt = 0; synchronizer flops = 0; last-served pointer = 1.
REQ-021 Reset asserted mid-PULSE SHALL drop S and R to 0 without waiting for a clock edge, and no ack SHALL be issued for the interrupted operation.
REQ-022 After rst deasserts, the first grant SHALL occur no earlier than the first clock edge with rst low.

Structure
REQ-023 A shared package SHALL hold the FSM state encoding (IDLE = 0, PULSE = 1, CHECK = 2, GAP = 3), the op encodings SET = 1 and RST = 0, and the counter width constant CNT_W = 8.
REQ-024 The 2-flop synchronizer SHALL be a separate sub-module named sync2, instantiated once per input (Q, Q_L) and reusable elsewhere in the lab.

Verification
All scenarios use PULSE_W = 2, GAP_W = 1, TIMEOUT = 8, and a behavioural RS latch model with 1-cycle delay.
REQ-025 Single request: reset, then req0 = 1, op0 = 1.
- S high exactly 2 cycles; R stays 0.
- ack0 pulses once with err = 0; Q = 1 afterwards; busy is low again after the GAP cycle.
REQ-026 Simultaneous requests: req = 2'b11, op0 = 1, op1 = 0.
- Requester 0 is served first (S pulse), then requester 1 (R pulse).
- At least 1 cycle with S = R = 0 separates the pulses; S & R is never 1.
REQ-027 Stuck latch: latch model forced to Q = 0, Q_L = 1; request set.
- ack0 with err = 1 exactly 8 cycles after CHECK entry.
REQ-028 Forbidden feedback: Q = Q_L = 1 held; request reset.
- Timeout, err = 1; no success ack.
REQ-029 Reset mid-PULSE: rst asserted one cycle into the S pulse.
- S = 0 in the same cycle, no ack issued, busy = 0.
- The next request is served normally.
REQ-030 Fairness: req = 2'b11 held continuously for 6 operations.
- ack order is 0, 1, 0, 1, 0, 1.

Source files
------------

// File: rtl/rs_latch_sequencer_pkg.sv
`default_nettype none
// rs_latch_sequencer_pkg: state and op encodings, counter width and the
// round-robin pick shared by the RS latch sequencer.
package rs_latch_sequencer_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    CHECK = 2'd2,
    GAP   = 2'd3
  } state_t;

  typedef enum logic {
    RST = 1'b0,
    SET = 1'b1
  } op_t;

  // With both requesters active the one not served last wins; otherwise the
  // single active requester wins.
  function automatic logic rr_pick(input logic [1:0] req_v, input logic last_v);
    if (req_v == 2'b11) begin
      return ~last_v;
    end
    return req_v[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_latch_sequencer_sync2.sv
`default_nettype none
// sync2: two-flop synchronizer for a single asynchronous bit, reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rs_latch_sequencer.sv
`default_nettype none
// rs_latch_sequencer: arbitrates two requesters onto an RS latch, pulses S or R,
// then confirms the synchronized latch outputs before acknowledging.
module rs_latch_sequencer
  import rs_latch_sequencer_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] op,
  input  logic       Q,
  input  logic       Q_L,
  output logic       S,
  output logic       R,
  output logic [1:0] ack,
  output logic       err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);
  localparam logic [CNT_W-1:0] CHECK_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  op_t              tgt, tgt_nxt;
  logic             grant, grant_nxt;
  logic             last, last_nxt;
  logic             s_nxt, r_nxt, err_nxt, busy_nxt;
  logic [1:0]       ack_nxt;
  logic             qs, qls;
  logic             confirmed;
  logic             win;

  sync2 u_sync_q (
    .clk (clk),
    .rst (rst),
    .d   (Q),
    .q   (qs)
  );

  sync2 u_sync_ql (
    .clk (clk),
    .rst (rst),
    .d   (Q_L),
    .q   (qls)
  );

  // Requiring complementary outputs means qs == qls can never count as success.
  assign confirmed = (qs == logic'(tgt)) && (qls == ~logic'(tgt));
  assign win       = rr_pick(req, last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      tgt   <= RST;
      grant <= 1'b0;
      last  <= 1'b1;
      S     <= 1'b0;
      R     <= 1'b0;
      ack   <= 2'b00;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      tgt   <= tgt_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      S     <= s_nxt;
      R     <= r_nxt;
      ack   <= ack_nxt;
      err   <= err_nxt;
      busy  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tgt_nxt   = tgt;
    grant_nxt = grant;
    last_nxt  = last;
    s_nxt     = 1'b0;
    r_nxt     = 1'b0;
    ack_nxt   = 2'b00;
    err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          grant_nxt = win;
          last_nxt  = win;
          tgt_nxt   = op_t'(op[win]);
          s_nxt     = op[win];
          r_nxt     = ~op[win];
          cnt_nxt   = '0;
          state_nxt = PULSE;
        end
      end
      PULSE: begin
        // The drive registered on entry already counts as the first pulse cycle.
        if (cnt == PULSE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
          s_nxt   = (tgt == SET);
          r_nxt   = (tgt == RST);
        end
      end
      CHECK: begin
        if (confirmed) begin
          ack_nxt[grant] = 1'b1;
          cnt_nxt        = '0;
          state_nxt      = GAP;
        end else if (cnt == CHECK_LAST) begin
          ack_nxt[grant] = 1'b1;
          err_nxt        = 1'b1;
          cnt_nxt        = '0;
          state_nxt      = GAP;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule
`default_nettype wire
